// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, op classes, FSM states and flag layout.
// Imported by the opcode decoder, the sequencer top and the decode stage.
package alu_pkg;

    localparam int ALU_OP_W = 14;

    localparam logic [ALU_OP_W-1:0] OP_NOT   = 14'h0A7;
    localparam logic [ALU_OP_W-1:0] OP_OR    = 14'h0BC;
    localparam logic [ALU_OP_W-1:0] OP_AND   = 14'h0D1;
    localparam logic [ALU_OP_W-1:0] OP_XOR   = 14'h0E6;
    localparam logic [ALU_OP_W-1:0] OP_SHFTR = 14'h0FB;
    localparam logic [ALU_OP_W-1:0] OP_SHFTL = 14'h110;
    localparam logic [ALU_OP_W-1:0] OP_ROTR  = 14'h125;
    localparam logic [ALU_OP_W-1:0] OP_ROTL  = 14'h13A;
    localparam logic [ALU_OP_W-1:0] OP_INC   = 14'h14F;
    localparam logic [ALU_OP_W-1:0] OP_DEC   = 14'h164;
    localparam logic [ALU_OP_W-1:0] OP_ADD   = 14'h179;
    localparam logic [ALU_OP_W-1:0] OP_ADDC  = 14'h18E;
    localparam logic [ALU_OP_W-1:0] OP_SUB   = 14'h1A3;
    localparam logic [ALU_OP_W-1:0] OP_SUBC  = 14'h1B8;
    localparam logic [ALU_OP_W-1:0] OP_SWAP  = 14'h1CD;
    localparam logic [ALU_OP_W-1:0] OP_EQ    = 14'h1E2;
    localparam logic [ALU_OP_W-1:0] OP_GT    = 14'h1F7;
    localparam logic [ALU_OP_W-1:0] OP_LT    = 14'h20C;
    localparam logic [ALU_OP_W-1:0] OP_GET   = 14'h221;
    localparam logic [ALU_OP_W-1:0] OP_LET   = 14'h236;

    typedef enum logic [2:0] {
        CLS_LOGIC,
        CLS_SHIFT,
        CLS_ARITH,
        CLS_SWAP,
        CLS_COMPARE,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_WB
    } state_t;

    // Architectural flag register layout: {Z, N, C}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier, shared between the decode stage and the ALU sequencer.
// Unknown codes map to CLS_ILLEGAL; uses_cin marks ops that consume the carry flag.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op_i,
    output op_class_t           op_class_o,
    output logic                uses_cin_o
);

    always_comb begin
        op_class_o = CLS_ILLEGAL;
        uses_cin_o = 1'b0;
        case (op_i)
            OP_NOT, OP_OR, OP_AND, OP_XOR:       op_class_o = CLS_LOGIC;
            OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL: op_class_o = CLS_SHIFT;
            OP_INC, OP_DEC, OP_ADD, OP_SUB:      op_class_o = CLS_ARITH;
            OP_ADDC, OP_SUBC: begin
                op_class_o = CLS_ARITH;
                uses_cin_o = 1'b1;
            end
            OP_SWAP:                             op_class_o = CLS_SWAP;
            OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET: op_class_o = CLS_COMPARE;
            default:                             op_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Runs one ALU operation at a time: accept request, drive ALU, capture result/flags, write back.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid holds payload until then.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 20,
    parameter int OP_W   = ALU_OP_W,
    parameter int DST_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [DST_W-1:0]  req_dst,
    output logic [OP_W-1:0]   alu_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [DST_W-1:0]  wb_dst,
    output logic [2:0]        flags,
    output logic              busy,
    output logic              illegal
);

    state_t            state_q;
    op_class_t         cls_q;
    op_class_t         req_cls;
    logic              req_uses_cin;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q, wb_data_q;
    logic [DST_W-1:0]  dst_q;
    logic              cin_q, illegal_q;
    logic [2:0]        flags_q;

    alu_op_decode u_decode (
        .op_i       (req_op),
        .op_class_o (req_cls),
        .uses_cin_o (req_uses_cin)
    );

    // ALU operand registers are only non-zero during EXEC/CAPT, so the ALU sees zeros while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_LOGIC;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            cin_q     <= 1'b0;
            wb_data_q <= '0;
            flags_q   <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_cls == CLS_ILLEGAL) begin
                            illegal_q <= 1'b1;
                        end else begin
                            cls_q   <= req_cls;
                            op_q    <= req_op;
                            a_q     <= req_a;
                            b_q     <= req_b;
                            dst_q   <= req_dst;
                            cin_q   <= req_uses_cin & flags_q[FLAG_C];
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: state_q <= ST_CAPT;
                ST_CAPT: begin
                    op_q    <= '0;
                    a_q     <= '0;
                    b_q     <= '0;
                    cin_q   <= 1'b0;
                    state_q <= ST_WB;
                    case (cls_q)
                        CLS_LOGIC, CLS_SHIFT: begin
                            wb_data_q[DATA_W-1:0] <= alu_result;
                            flags_q[FLAG_Z]       <= (alu_result == '0);
                            flags_q[FLAG_N]       <= alu_result[DATA_W-1];
                        end
                        CLS_ARITH: begin
                            wb_data_q       <= alu_result;
                            flags_q[FLAG_Z] <= (alu_result == '0);
                            flags_q[FLAG_N] <= alu_result[DATA_W-1];
                            flags_q[FLAG_C] <= alu_carry;
                        end
                        CLS_SWAP: wb_data_q <= b_q;
                        default: begin
                            // Compares only update Z/N and never write back.
                            flags_q[FLAG_Z] <= alu_z;
                            flags_q[FLAG_N] <= alu_n;
                            state_q         <= ST_IDLE;
                        end
                    endcase
                end
                ST_WB: begin
                    if (wb_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign wb_valid  = (state_q == ST_WB);
    assign wb_data   = wb_data_q;
    assign wb_dst    = dst_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;
    assign alu_instr = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer that owns the 20-bit ALU and runs one operation at a time for the CPU core. It accepts an operation request over a valid/ready handshake and drives the ALU's instruction and operand inputs. It captures the ALU's result and flag outputs into registers, maintains the architectural Z/N/C flag register, and returns the result over a writeback handshake. It sits between the decode stage and the register-file write port.

## Interface
Parameters:
- DATA_W, 20, operand/result width
- OP_W, 14, ALU instruction code width
- DST_W, 4, destination register index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  OP_W  ALU instruction code
- req_a, req_b  in  DATA_W  operands
- req_dst  in  DST_W  destination register index
- alu_instr  out  OP_W  to ALU instruction input
- alu_a, alu_b  out  DATA_W  to ALU operand inputs
- alu_cin  out  1  carry/borrow-in to ALU (= C flag)
- alu_result  in  DATA_W  ALU combinational result
- alu_carry, alu_z, alu_n  in  1  ALU carry-out and compare flags
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  register file accepts writeback
- wb_data  out  DATA_W  captured result
- wb_dst  out  DST_W  captured destination
- flags  out  3  {Z,N,C} architectural flag register
- busy  out  1  state != IDLE
- illegal  out  1  one-cycle pulse on unknown opcode

## Operation
- States: IDLE, EXEC, CAPT, WB.
- IDLE: req_ready=1; on req_valid&req_ready, latch op/a/b/dst → EXEC. Unknown op (not in package list): no latch, illegal pulses next cycle, stay IDLE, flags unchanged.
- EXEC: alu_instr/alu_a/alu_b/alu_cin driven from latched values, held stable all cycle → CAPT.
- CAPT: result, carry, and compare flags sampled at end of cycle. Classes are defined by the decoder:
  - LOGIC/SHIFT (NOT, OR, AND, XOR, SHFTR, SHFTL, ROTR, ROTL): Z=(result==0), N=result[DATA_W-1], C unchanged → WB.
  - ARITH (INC, DEC, ADD, ADDC, SUB, SUBC): Z, N as above; C=alu_carry → WB.
  - SWAP: wb_data=b latched, flags unchanged → WB.
  - COMPARE (EQ, GT, LT, GET, LET): Z=alu_z, N=alu_n, C unchanged; no writeback → IDLE.
- WB: wb_valid=1 with wb_data/wb_dst stable until wb_ready; on wb_valid&wb_ready → IDLE.
- alu_* outputs are 0 in IDLE (ALU idle, no spurious decode).
- Result width: ALU result taken as-is, DATA_W bits; no extension.

## Timing
- Reset (async, any state, mid-operation included): state=IDLE; req_ready=1 after deassert; wb_valid=0, wb_data=0, wb_dst=0, flags=3'b000, busy=0, illegal=0, alu_*=0. An in-flight op is dropped with no writeback.
- Accept at edge T; EXEC cycle T..T+1; CAPT cycle T+1..T+2; wb_valid asserted from T+2. Minimum accept-to-accept period is 4 cycles with wb_ready held high, 3 cycles for COMPARE.
- req_ready=0 in EXEC/CAPT/WB; requests then are back-pressured, not dropped.
- wb_ready low for N cycles stretches WB by N; flags already updated at CAPT edge.
- ADDC/SUBC use C as it stood at the accept edge (flag register unchanged until CAPT).
- req_valid asserted in the same cycle WB completes: not accepted until next cycle (IDLE).

## Structure
- Package alu_pkg: ALU opcode localparams (0x0A7 NOT … 0x236 LET, step 0x15), op-class enum {LOGIC, SHIFT, ARITH, SWAP, COMPARE, ILLEGAL}, state enum, flag bit indices.
- Sub-module alu_op_decode: combinational opcode → class plus uses_cin; shared with the decode stage.

## Test plan
- ADD a=0x00005, b=0x00003, wb_ready=1 → wb_valid at T+2, wb_data=0x00008, flags Z=0 N=0 C=0, req_ready back at T+3.
- ADD a=0xFFFFF, b=0x00001 (ALU carry=1) then ADDC a=0x00001, b=0x00001 → first wb_data=0x00000, Z=1 C=1; second alu_cin=1, wb_data=0x00003.
- EQ a=b=0x12345 → no wb_valid, Z=alu_z=1, req_ready high at T+2.
- AND with wb_ready low 5 cycles → wb_valid/wb_data held 5 cycles, second req_valid stalled, accepted the cycle after handshake.
- req_op=0x3FFF → illegal pulse 1 cycle, no busy, flags unchanged.
- rst_n low during CAPT of SUB → all outputs to reset values immediately, no writeback after release.
